// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of a counter that must hold every value from 0 up to n inclusive.
  function automatic int calc_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_bitstream_loader.sv
// Parallel-to-serial loader for a ccff_head -> ccff_tail configuration chain.
// Words arrive over valid/ready and leave LSB-first on ccff_head; the chain
// only advances on cycles where ccff_clk_en is high, so it holds while the
// source stalls. Bits falling off ccff_tail are folded into tail_parity.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int  DATA_W    = 32,
  parameter int  CHAIN_LEN = 800,
  localparam int CNT_W     = calc_cnt_w(CHAIN_LEN)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_left,
  output logic              tail_parity
);

  // word_cnt never exceeds DATA_W
  localparam int WC_W = calc_cnt_w(DATA_W);

  state_e            state;
  logic [DATA_W-1:0] shreg;      // bits of the current word still behind ccff_head
  logic [WC_W-1:0]   word_cnt;   // shifts remaining in the current word

  // Only the low bits_left bits of the final word are ever shifted out.
  logic [WC_W-1:0] word_take;
  always_comb begin
    word_take = WC_W'(DATA_W);
    if (int'(bits_left) < DATA_W) word_take = WC_W'(bits_left);
  end

  // Loader FSM; every output is a register so the chain sees glitch-free
  // data and clock-enable for the whole cycle.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      ccff_head   <= 1'b0;
      ccff_clk_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bits_left   <= '0;
      tail_parity <= 1'b0;
      shreg       <= '0;
      word_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            bits_left   <= CNT_W'(CHAIN_LEN);
            tail_parity <= 1'b0;
          end
        end
        LOAD: begin
          // in_ready is high for the whole LOAD state, so valid alone completes the handshake
          if (in_valid) begin
            state       <= SHIFT;
            in_ready    <= 1'b0;
            ccff_clk_en <= 1'b1;
            ccff_head   <= in_data[0];
            shreg       <= in_data >> 1;
            word_cnt    <= word_take;
          end
        end
        SHIFT: begin
          // ccff_tail is the bit the chain displaces at this same gated edge
          tail_parity <= tail_parity ^ ccff_tail;
          if (bits_left != '0) bits_left <= bits_left - CNT_W'(1);
          word_cnt <= word_cnt - WC_W'(1);
          if (word_cnt <= WC_W'(1)) begin
            // last bit of this word is on ccff_head now; park the chain
            ccff_clk_en <= 1'b0;
            ccff_head   <= 1'b0;
            shreg       <= '0;
            if (bits_left <= CNT_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end else begin
            ccff_head <= shreg[0];
            shreg     <= shreg >> 1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Parallel-to-serial loader driving a configuration-chain segment (a string of `mux_tree_tapbuf_sizeN_mem`-style DFF stages linked ccff_head→ccff_tail). Accepts bitstream words over a valid/ready interface, shifts exactly CHAIN_LEN bits into the chain head, and gates chain shifting through a clock-enable so the chain holds whenever data is stalled. Simultaneously folds the bits leaving the chain tail into a parity bit for readback checking. Sits directly upstream of the chain, between the bitstream source and the fabric.

## Interface
- DATA_W, 32, bitstream word width (≥2)
- CHAIN_LEN, 800, number of DFFs in the driven chain (≥1)
- CNT_W, $clog2(CHAIN_LEN+1), width of bit counter (derived, not overridden)

- prog_clk  in  1  configuration clock; all state on rising edge
- prog_reset_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to begin a load; ignored unless IDLE
- in_data  in  DATA_W  bitstream word, bit 0 shifted first
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a word this cycle
- ccff_head  out  1  serial data to chain head
- ccff_clk_en  out  1  enable for the external clock gate feeding the chain's prog_clk; chain shifts at each edge where high
- ccff_tail  in  1  chain tail (last DFF output)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when load completes
- bits_left  out  CNT_W  bits still to shift
- tail_parity  out  1  XOR of every ccff_tail value sampled on shifting edges of the current/last load

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: in_ready=0, ccff_clk_en=0. start=1 → LOAD; bits_left←CHAIN_LEN, tail_parity←0.
- LOAD: in_ready=1, ccff_clk_en=0. On in_valid&in_ready: shreg←in_data, word_cnt←min(DATA_W, bits_left) → SHIFT. No handshake → stay (chain holds).
- SHIFT: ccff_head=shreg[0] (registered), ccff_clk_en=1, in_ready=0. Each cycle: shreg>>1, word_cnt−1, bits_left−1, tail_parity^=ccff_tail. When word_cnt=1: bits_left=1 → DONE, else → LOAD.
- DONE: done=1 for one cycle, busy=1, ccff_clk_en=0 → IDLE.
- Partial last word: only bits_left LSBs used; upper bits discarded, never shifted.
- start in any non-IDLE state ignored; in_valid outside LOAD ignored (no word consumed).
- bits_left saturates at 0; never wraps.
- ccff_head=0 whenever ccff_clk_en=0.

## Timing
- Reset (prog_reset_n=0 at an edge): state IDLE, in_ready=0, ccff_head=0, ccff_clk_en=0, busy=0, done=0, bits_left=0, tail_parity=0, shreg=0. Reset mid-load aborts immediately; chain contents left partial, no done.
- start at edge k → LOAD visible cycle k+1.
- Per word: 1 LOAD cycle (min) + n SHIFT cycles; throughput DATA_W bits per DATA_W+1 cycles with in_valid held high.
- ccff_head/ccff_clk_en are register outputs, stable for full cycle; chain captures ccff_head at the gated edge ending that cycle.
- tail_parity samples ccff_tail in the same cycle, i.e. bit being displaced; after load, equals parity of prior chain contents.
- Exactly CHAIN_LEN cycles with ccff_clk_en=1 per load.

## Structure
- Package ccff_loader_pkg: state enum (IDLE, LOAD, SHIFT, DONE), CNT_W calculation function.
- Single module; no sub-module needed. Clock gate cell external.

## Test plan
- CHAIN_LEN=70, DATA_W=32, in_valid always high, start at cycle 0 → accepts at cycles 1, 34, 67; ccff_clk_en high 70 cycles; done at cycle 74; model chain holds exactly the 70 LSB-first bits.
- Stall: in_valid low 5 cycles in second LOAD → ccff_clk_en=0, chain model unchanged for those cycles; final content identical to no-stall run.
- Partial word: CHAIN_LEN=5, in_data=0xFFFF_FFE5 → bits 1,0,1,0,0 shifted; upper bits never appear on ccff_head; done after 1 word.
- Readback: preload chain model with 0x2B (7 bits, 4 ones), CHAIN_LEN=7 → tail_parity=0; with 0x2A → 1.
- start pulsed during SHIFT and in_valid during SHIFT → ignored; no extra word consumed, bit count unchanged.
- prog_reset_n low during SHIFT at bits_left=40 → next cycle IDLE, all outputs at reset values; fresh start loads full CHAIN_LEN.
